// File: rtl/gpu_cmd_pkg.sv
// rtl/gpu_cmd_pkg.sv - shared GPU command field widths, shape codes and command word layout
package gpu_cmd_pkg;

    localparam int SHAPE_W    = 4;
    localparam int COLOR_W    = 16;
    localparam int DATA_W     = 76;
    localparam int NUM_SHAPES = 6;

    typedef enum logic [SHAPE_W-1:0] {
        LINE     = 4'd0,
        RECT     = 4'd1,
        FILLRECT = 4'd2,
        CIRCLE   = 4'd3,
        TRIANGLE = 4'd4,
        BLIT     = 4'd5
    } shape_e;

    // shape is kept as a raw field rather than shape_e so illegal codes stay representable
    typedef struct packed {
        logic [SHAPE_W-1:0] shape;
        logic [COLOR_W-1:0] color;
        logic [DATA_W-1:0]  opdata;
    } cmd_t;

endpackage

// File: rtl/opcode_decoder_pipe_if.sv
// rtl/opcode_decoder_pipe_if.sv - command-in / decoded-out handshake bundle for opcode_decoder_pipe
interface opcode_decoder_pipe_if #(
    parameter int SHAPE_W = gpu_cmd_pkg::SHAPE_W,
    parameter int COLOR_W = gpu_cmd_pkg::COLOR_W,
    parameter int DATA_W  = gpu_cmd_pkg::DATA_W
);
    localparam int OP_W = SHAPE_W + COLOR_W + DATA_W;

    logic               in_valid;
    logic               in_ready;
    logic [OP_W-1:0]    in_opcode;
    logic               out_valid;
    logic               out_ready;
    logic [SHAPE_W-1:0] out_shape;
    logic [COLOR_W-1:0] out_color;
    logic [DATA_W-1:0]  out_opdata;
    logic               out_illegal;

    modport master (
        output in_valid, in_opcode, out_ready,
        input  in_ready, out_valid, out_shape, out_color, out_opdata, out_illegal
    );

    modport slave (
        input  in_valid, in_opcode, out_ready,
        output in_ready, out_valid, out_shape, out_color, out_opdata, out_illegal
    );

endinterface

// File: rtl/opdec_fifo.sv
// rtl/opdec_fifo.sv - generic synchronous FIFO with registered occupancy count
module opdec_fifo #(
    parameter  int WIDTH = 96,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // storage is not reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/opcode_decoder_pipe.sv
// rtl/opcode_decoder_pipe.sv - buffered GPU opcode splitter with registered decode stage
// Optional OPDEC_DROP_ILLEGAL_EN: discard illegal shapes at the FIFO-to-output load.
module opcode_decoder_pipe #(
    parameter  int SHAPE_W    = gpu_cmd_pkg::SHAPE_W,
    parameter  int COLOR_W    = gpu_cmd_pkg::COLOR_W,
    parameter  int DATA_W     = gpu_cmd_pkg::DATA_W,
    parameter  int DEPTH      = 4,
    parameter  int NUM_SHAPES = gpu_cmd_pkg::NUM_SHAPES,
    localparam int OP_W       = SHAPE_W + COLOR_W + DATA_W,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    opcode_decoder_pipe_if.slave  bus,
    output logic [CW-1:0]         fifo_count,
    output logic [7:0]            err_count
);

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               load;
    logic               err_inc;
    logic [OP_W-1:0]    head;
    logic [SHAPE_W-1:0] head_shape;
    logic [COLOR_W-1:0] head_color;
    logic [DATA_W-1:0]  head_opdata;
    logic               head_illegal;

    logic               out_valid_q;
    logic [SHAPE_W-1:0] out_shape_q;
    logic [COLOR_W-1:0] out_color_q;
    logic [DATA_W-1:0]  out_opdata_q;

    // in_ready comes from the registered count only, so a same-cycle pop never frees a slot
    assign bus.in_ready = !fifo_full;
    assign push         = bus.in_valid && !fifo_full;
    assign pop          = !fifo_empty && (!out_valid_q || bus.out_ready);

    opdec_fifo #(
        .WIDTH (OP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (bus.in_opcode),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_shape   = head[OP_W-1 -: SHAPE_W];
    assign head_color   = head[DATA_W +: COLOR_W];
    assign head_opdata  = head[DATA_W-1:0];
    assign head_illegal = (32'(head_shape) >= NUM_SHAPES);

`ifdef OPDEC_DROP_ILLEGAL_EN
    assign load            = pop && !head_illegal;
    assign err_inc         = pop && head_illegal;
    assign bus.out_illegal = 1'b0;
`else
    logic out_illegal_q;

    assign load            = pop;
    assign err_inc         = out_valid_q && bus.out_ready && out_illegal_q;
    assign bus.out_illegal = out_illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_illegal_q <= 1'b0;
        end else if (load) begin
            out_illegal_q <= head_illegal;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_shape_q  <= '0;
            out_color_q  <= '0;
            out_opdata_q <= '0;
        end else if (load) begin
            out_valid_q  <= 1'b1;
            out_shape_q  <= head_shape;
            out_color_q  <= head_color;
            out_opdata_q <= head_opdata;
        end else if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_inc && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_shape  = out_shape_q;
    assign bus.out_color  = out_color_q;
    assign bus.out_opdata = out_opdata_q;

endmodule
